mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. Decodes the opcode/funct held in the instruction register and steps each instruction through IF/ID/EX/MEM/WB, driving every datapath enable. Sits directly upstream of the register file: it produces the register-file write enable, the write-address select and the write-data select consumed there. The register file commits on the falling edge inside the cycle where `RegWrite` is high.

---
 rtl/mc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control sequencer stepping IF/ID/EX/MEM/WB.
// Define MC_CTRL_MEMWAIT_EN to stretch IF and MEM until mem_ready is high.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] inst_op,
    input  logic [5:0] inst_funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALU_Control,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILL,
        C_RTYPE,
        C_JR,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_J,
        C_JAL,
        C_ITYPE
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b011;

    localparam logic [1:0] BSEL_REG = 2'd0;
    localparam logic [1:0] BSEL_4   = 2'd1;
    localparam logic [1:0] BSEL_IMM = 2'd2;
    localparam logic [1:0] BSEL_BR  = 2'd3;

    localparam logic [1:0] PC_ALU = 2'd0;
    localparam logic [1:0] PC_OUT = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_RS  = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;
    localparam logic [1:0] WD_LUI = 2'd3;

    state_t     st;
    state_t     nxt;
    cls_t       cls;
    logic [2:0] r_alu;
    logic [2:0] i_alu;
    logic       mem_go;
    logic       pc_wr;
    logic       ir_wr;
    logic       mem_wr;
    logic       reg_wr;
    logic       ill;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    always_comb begin
        cls = C_ILL;
        case (inst_op)
            OP_RTYPE: begin
                case (inst_funct)
                    FN_JR: cls = C_JR;
                    FN_SRL, FN_ADD, FN_SUB, FN_AND,
                    FN_OR, FN_XOR, FN_NOR, FN_SLT: cls = C_RTYPE;
                    default: cls = C_ILL;
                endcase
            end
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_BNE:  cls = C_BNE;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_LUI: cls = C_ITYPE;
            default: cls = C_ILL;
        endcase
    end

    always_comb begin
        r_alu = ALU_ADD;
        case (inst_funct)
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            FN_NOR:  r_alu = ALU_NOR;
            FN_XOR:  r_alu = ALU_XOR;
            FN_SRL:  r_alu = ALU_SRL;
            default: r_alu = ALU_ADD;
        endcase
    end

    // lui falls through to add; its result comes from the imm<<16 mux leg
    always_comb begin
        i_alu = ALU_ADD;
        case (inst_op)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_SLTI: i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        nxt         = S_IF;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        ill         = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = DST_RT;
        MemtoReg    = WD_ALU;
        ALUSrcB     = BSEL_REG;
        PCSource    = PC_ALU;
        ALU_Control = ALU_AND;
        case (st)
            S_IF: begin
                MemRead     = 1'b1;
                ALUSrcB     = BSEL_4;
                ALU_Control = ALU_ADD;
                pc_wr       = mem_go;
                ir_wr       = mem_go;
                nxt         = mem_go ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB     = BSEL_BR;
                ALU_Control = ALU_ADD;
                case (cls)
                    C_ILL: begin
                        ill = 1'b1;
                        nxt = S_IF;
                    end
                    C_JAL:   nxt = S_WB;
                    default: nxt = S_EX;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_RTYPE: begin
                        ALUSrcA     = 1'b1;
                        ALUSrcB     = BSEL_REG;
                        ALU_Control = r_alu;
                        nxt         = S_WB;
                    end
                    C_JR: begin
                        pc_wr    = 1'b1;
                        PCSource = PC_RS;
                    end
                    C_LW, C_SW: begin
                        ALUSrcA     = 1'b1;
                        ALUSrcB     = BSEL_IMM;
                        ALU_Control = ALU_ADD;
                        nxt         = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        ALUSrcA     = 1'b1;
                        ALUSrcB     = BSEL_REG;
                        ALU_Control = ALU_SUB;
                        PCSource    = PC_OUT;
                        pc_wr       = (cls == C_BEQ) ? zero : !zero;
                    end
                    C_J: begin
                        pc_wr    = 1'b1;
                        PCSource = PC_JMP;
                    end
                    C_ITYPE: begin
                        ALUSrcA     = 1'b1;
                        ALUSrcB     = BSEL_IMM;
                        ALU_Control = i_alu;
                        nxt         = S_WB;
                    end
                    default: nxt = S_IF;
                endcase
            end
            S_MEM: begin
                IorD = 1'b1;
                case (cls)
                    C_LW: begin
                        MemRead = 1'b1;
                        nxt     = mem_go ? S_WB : S_MEM;
                    end
                    C_SW: begin
                        mem_wr = mem_go;
                        nxt    = mem_go ? S_IF : S_MEM;
                    end
                    default: nxt = S_IF;
                endcase
            end
            S_WB: begin
                reg_wr = 1'b1;
                case (cls)
                    C_RTYPE: RegDst = DST_RD;
                    C_LW:    MemtoReg = WD_MDR;
                    C_ITYPE: MemtoReg = (inst_op == OP_LUI) ? WD_LUI : WD_ALU;
                    C_JAL: begin
                        RegDst   = DST_RA;
                        MemtoReg = WD_PC;
                        pc_wr    = 1'b1;
                        PCSource = PC_JMP;
                    end
                    default: reg_wr = 1'b0;
                endcase
            end
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IF;
        end else begin
            st <= nxt;
        end
    end

    // write enables are masked combinationally so nothing commits while held in reset
    assign PCWrite  = pc_wr & ~rst;
    assign IRWrite  = ir_wr & ~rst;
    assign MemWrite = mem_wr & ~rst;
    assign RegWrite = reg_wr & ~rst;
    assign illegal  = ill & ~rst;
    assign state    = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, self-checking bench for the mc_ctrl sequencer.
// Each task drives one scenario and checks hand-computed expectations.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] inst_op = 6'd0;
    logic [5:0] inst_funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALU_Control, state;
    logic       illegal;

    int errors = 0;
    int checks = 0;
    int rw_pulses = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .inst_op(inst_op), .inst_funct(inst_funct),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALU_Control(ALU_Control), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (RegWrite === 1'b1) rw_pulses++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL rst_state got=%0d exp=0", state);
        end
        checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite, illegal} !== 5'b0) begin
            errors++;
            $display("FAIL rst_enables got=%b exp=00000",
                     {PCWrite, IRWrite, MemWrite, RegWrite, illegal});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({MemRead, IRWrite, PCWrite, ALUSrcB, ALU_Control} !== {3'b111, 2'd1, 3'b010}) begin
            errors++;
            $display("FAIL rst_first_if got=%b%b%b %0d %b exp=111 1 010",
                     MemRead, IRWrite, PCWrite, ALUSrcB, ALU_Control);
        end
    endtask

    task automatic test_add;
        logic [2:0] exp_st [5];
        int base;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        inst_op = 6'b000000; inst_funct = 6'b100000;
        base = rw_pulses;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (state !== exp_st[c]) begin
                errors++; $display("FAIL add_state[%0d] got=%0d exp=%0d", c, state, exp_st[c]);
            end
            if (c == 1) begin
                checks++;
                if (ALUSrcB !== 2'd3 || ALU_Control !== 3'b010) begin
                    errors++; $display("FAIL add_id got=%0d/%b exp=3/010", ALUSrcB, ALU_Control);
                end
            end
            if (c == 2) begin
                checks++;
                if ({ALUSrcA, ALUSrcB, ALU_Control, RegWrite} !== {1'b1, 2'd0, 3'b010, 1'b0}) begin
                    errors++;
                    $display("FAIL add_ex got=%b %0d %b %b exp=1 0 010 0",
                             ALUSrcA, ALUSrcB, ALU_Control, RegWrite);
                end
            end
            if (c == 3) begin
                checks++;
                if ({RegWrite, RegDst, MemtoReg} !== {1'b1, 2'd1, 2'd0}) begin
                    errors++;
                    $display("FAIL add_wb got=%b %0d %0d exp=1 1 0", RegWrite, RegDst, MemtoReg);
                end
            end
            if (c < 4) tick();
        end
        checks++;
        if (rw_pulses - base !== 1) begin
            errors++; $display("FAIL add_rw_pulses got=%0d exp=1", rw_pulses - base);
        end
    endtask

    task automatic test_rtype_alu;
        logic [5:0] fn [7];
        logic [2:0] op [7];
        fn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b100110, 6'b000010};
        op = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b011, 3'b101};
        for (int i = 0; i < 7; i++) begin
            inst_op = 6'd0; inst_funct = fn[i];
            tick(); tick();
            checks++;
            if (state !== 3'd2 || ALU_Control !== op[i]) begin
                errors++;
                $display("FAIL rtype_alu[%0d] got=%0d/%b exp=2/%b", i, state, ALU_Control, op[i]);
            end
            tick(); tick();
        end
    endtask

    task automatic test_lw_sw;
        logic [2:0] lw_st [6];
        logic [2:0] sw_st [5];
        logic       sw_mw [4];
        lw_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        sw_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        sw_mw = '{1'b0, 1'b0, 1'b0, 1'b1};
        inst_op = 6'b100011; inst_funct = 6'd0;
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (state !== lw_st[c]) begin
                errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", c, state, lw_st[c]);
            end
            if (c == 2) begin
                checks++;
                if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'd2 || ALU_Control !== 3'b010) begin
                    errors++; $display("FAIL lw_ex got=%b %0d %b exp=1 2 010", ALUSrcA, ALUSrcB, ALU_Control);
                end
            end
            if (c == 3) begin
                checks++;
                if ({IorD, MemRead, MemWrite, RegWrite} !== 4'b1100) begin
                    errors++; $display("FAIL lw_mem got=%b exp=1100", {IorD, MemRead, MemWrite, RegWrite});
                end
            end
            if (c == 4) begin
                checks++;
                if ({RegWrite, RegDst, MemtoReg} !== {1'b1, 2'd0, 2'd1}) begin
                    errors++; $display("FAIL lw_wb got=%b %0d %0d exp=1 0 1", RegWrite, RegDst, MemtoReg);
                end
            end
            if (c < 5) tick();
        end
        inst_op = 6'b101011;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (state !== sw_st[c]) begin
                errors++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", c, state, sw_st[c]);
            end
            if (c < 4) begin
                checks++;
                if (MemWrite !== sw_mw[c] || RegWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL sw_we[%0d] got=%b/%b exp=%b/0", c, MemWrite, RegWrite, sw_mw[c]);
                end
                tick();
            end
        end
    endtask

    task automatic test_branch;
        logic [5:0] bop [4];
        logic       bz [4];
        logic       bpw [4];
        bop = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        bz  = '{1'b1, 1'b0, 1'b0, 1'b1};
        bpw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            inst_op = bop[i]; zero = bz[i];
            tick(); tick();
            checks++;
            if ({state, PCWrite, PCSource, ALU_Control} !== {3'd2, bpw[i], 2'd1, 3'b110}) begin
                errors++;
                $display("FAIL branch_ex[%0d] got=%0d %b %0d %b exp=2 %b 1 110",
                         i, state, PCWrite, PCSource, ALU_Control, bpw[i]);
            end
            tick();
            checks++;
            if (state !== 3'd0) begin
                errors++; $display("FAIL branch_done[%0d] got=%0d exp=0", i, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps;
        int base;
        base = rw_pulses;
        inst_op = 6'b000011;
        tick(); tick();
        checks++;
        if ({state, RegDst, MemtoReg, RegWrite, PCWrite, PCSource} !== {3'd4, 2'd2, 2'd2, 1'b1, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL jal_wb got=%0d %0d %0d %b %b %0d exp=4 2 2 1 1 2",
                     state, RegDst, MemtoReg, RegWrite, PCWrite, PCSource);
        end
        tick();
        checks++;
        if (state !== 3'd0 || rw_pulses - base !== 1) begin
            errors++; $display("FAIL jal_done got=%0d/%0d exp=0/1", state, rw_pulses - base);
        end
        inst_op = 6'b000010;
        tick(); tick();
        checks++;
        if ({state, PCWrite, PCSource} !== {3'd2, 1'b1, 2'd2}) begin
            errors++; $display("FAIL j_ex got=%0d %b %0d exp=2 1 2", state, PCWrite, PCSource);
        end
        inst_op = 6'b000000; inst_funct = 6'b001000;
        tick(); tick(); tick();
        checks++;
        if ({state, PCWrite, PCSource, RegWrite} !== {3'd2, 1'b1, 2'd3, 1'b0}) begin
            errors++; $display("FAIL jr_ex got=%0d %b %0d %b exp=2 1 3 0", state, PCWrite, PCSource, RegWrite);
        end
        tick();
        checks++;
        if (state !== 3'd0 || rw_pulses - base !== 1) begin
            errors++; $display("FAIL jr_done got=%0d/%0d exp=0/1", state, rw_pulses - base);
        end
    endtask

    task automatic test_itype;
        logic [5:0] iop [5];
        logic [2:0] ialu [4];
        iop  = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111};
        ialu = '{3'b010, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            inst_op = iop[i];
            tick(); tick();
            if (i < 4) begin
                checks++;
                if ({state, ALUSrcA, ALUSrcB, ALU_Control} !== {3'd2, 1'b1, 2'd2, ialu[i]}) begin
                    errors++;
                    $display("FAIL itype_ex[%0d] got=%0d %b %0d %b exp=2 1 2 %b",
                             i, state, ALUSrcA, ALUSrcB, ALU_Control, ialu[i]);
                end
            end
            tick();
            checks++;
            if ({state, RegWrite, RegDst, MemtoReg} !== {3'd4, 1'b1, 2'd0, (i == 4) ? 2'd3 : 2'd0}) begin
                errors++;
                $display("FAIL itype_wb[%0d] got=%0d %b %0d %0d", i, state, RegWrite, RegDst, MemtoReg);
            end
            tick();
        end
    endtask

    task automatic test_illegal;
        logic [5:0] bop [2];
        logic [5:0] bfn [2];
        bop = '{6'b111111, 6'b000000};
        bfn = '{6'b000000, 6'b111111};
        for (int i = 0; i < 2; i++) begin
            inst_op = bop[i]; inst_funct = bfn[i];
            #1;
            checks++;
            if (illegal !== 1'b0) begin
                errors++; $display("FAIL ill_if[%0d] got=%b exp=0", i, illegal);
            end
            tick();
            checks++;
            if ({state, illegal, RegWrite, MemWrite, PCWrite} !== {3'd1, 4'b1000}) begin
                errors++;
                $display("FAIL ill_id[%0d] got=%0d %b%b%b%b exp=1 1000",
                         i, state, illegal, RegWrite, MemWrite, PCWrite);
            end
            tick();
            checks++;
            if (state !== 3'd0 || illegal !== 1'b0) begin
                errors++; $display("FAIL ill_after[%0d] got=%0d/%b exp=0/0", i, state, illegal);
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        inst_op = 6'b000000; inst_funct = 6'b100000;
        tick(); tick();
        base = rw_pulses;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got=%0d/%b exp=0/0", state, RegWrite);
        end
        tick();
        checks++;
        if ({state, PCWrite, IRWrite, RegWrite} !== {3'd0, 3'b000}) begin
            errors++;
            $display("FAIL rstmid_hold got=%0d %b%b%b exp=0 000", state, PCWrite, IRWrite, RegWrite);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state, MemRead, IRWrite} !== {3'd0, 2'b11}) begin
            errors++; $display("FAIL rstmid_if got=%0d %b%b exp=0 11", state, MemRead, IRWrite);
        end
        checks++;
        if (rw_pulses - base !== 0) begin
            errors++; $display("FAIL rstmid_rw got=%0d exp=0", rw_pulses - base);
        end
    endtask

    task automatic test_memwait;
        int irs;
        irs = 0;
        inst_op = 6'b000000; inst_funct = 6'b100000;
`ifdef MC_CTRL_MEMWAIT_EN
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            #1;
            checks++;
            if (state !== 3'd0 || MemRead !== 1'b1) begin
                errors++; $display("FAIL wait_if[%0d] got=%0d/%b exp=0/1", c, state, MemRead);
            end
            if (IRWrite === 1'b1) irs++;
            tick();
        end
        mem_ready = 1'b1;
        checks++;
        if (state !== 3'd1 || irs !== 1) begin
            errors++; $display("FAIL wait_irwrite got=%0d/%0d exp=1/1", state, irs);
        end
        tick(); tick(); tick();
`else
        mem_ready = 1'b0;
        #1;
        if (IRWrite === 1'b1) irs++;
        tick(); tick(); tick(); tick();
        checks++;
        if (state !== 3'd0 || irs !== 1) begin
            errors++; $display("FAIL nowait got=%0d/%0d exp=0/1", state, irs);
        end
        mem_ready = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype_alu();
        test_lw_sw();
        test_branch();
        test_jumps();
        test_itype();
        test_illegal();
        test_reset_mid();
        test_memwait();
        test_add();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
